adder_tree_feeder: RTL and testbench
====================================

// Module: adder_tree_feeder
// PURPOSE
//  Producer/consumer end of the 8-lane adder-tree interface. Collects a serial operand stream
//  (valid/ready) into 8 parallel lanes, launches them into the external adder tree, waits the
//  fixed tree latency, captures the full-width sum and returns it on a valid/ready result port.
//  Sits between a streaming source and adder_tree_top-style reduction logic.
// PARAMETERS
//  WIDTH     23  operand width per lane (bits)
//  LANES     8   lanes per group; fixed at 8 (tree depth 3)
//  TREE_LAT  2   cycles from lane launch edge to valid tree_sum (tree input reg + output reg)
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous, active-high reset
//  s_valid    in   1            operand beat valid
//  s_ready    out  1            feeder accepts operand
//  s_data     in   WIDTH        operand
//  s_last     in   1            last operand of short group (used only with ADDER_FEED_PARTIAL_EN)
//  lane_data  out  LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]; lane 0 = first beat of group
//  lane_valid out  1            one-cycle launch strobe to tree
//  tree_sum   in   WIDTH+3      sum returned by tree
//  m_valid    out  1            result valid
//  m_ready    in   1            result consumer ready
//  m_sum      out  WIDTH+3      captured sum, full width, no truncation
//  m_count    out  4            operands in group (1..8)
// BEHAVIOUR
//  - Reset: state=FILL, idx=0, lane_data=0, lane_valid=0, m_valid=0, m_sum=0, m_count=0;
//    s_ready=0 while rst high, 1 on first cycle after. Reset mid-group/mid-wait discards all.
//  - FSM FILL -> LAUNCH -> WAIT -> HOLD -> FILL.
//  - FILL: s_ready=1. Beat (s_valid&s_ready) writes lane[idx], idx++. Beat with idx==7 -> LAUNCH.
//    Non-written lanes retain 0 (cleared on entry to FILL).
//  - LAUNCH: one cycle, lane_valid=1, s_ready=0. -> WAIT, wait counter=TREE_LAT-1.
//  - WAIT: counter decrements; tree_sum sampled on the edge TREE_LAT cycles after the launch
//    edge. lane_data held constant from LAUNCH until capture. -> HOLD on capture.
//  - HOLD: m_valid=1, m_sum/m_count stable until m_ready. Handshake cycle: m_valid drops next
//    cycle, lanes cleared, idx=0, -> FILL. s_ready=0 throughout LAUNCH/WAIT/HOLD.
//  - Latency: last beat accepted cycle T -> lane_valid cycle T+1 -> m_valid cycle T+2+TREE_LAT.
//  - Arithmetic: feeder performs no addition; m_sum = tree_sum verbatim, WIDTH+3 bits.
//  - m_ready held high in HOLD: single-cycle result; m_ready while !m_valid ignored.
// CONFIGURATION
//  ADDER_FEED_PARTIAL_EN defined: beat with s_last=1 in FILL ends group early -> LAUNCH;
//    remaining lanes stay 0; m_count = beats accepted. s_last on idx==7 beat same as full.
//  Undefined: s_last ignored; every group is exactly 8 beats; m_count always 8.
// STRUCTURE
//  - Package adder_feed_pkg: WIDTH, LANES, TREE_LAT defaults, SUM_W=WIDTH+3, IDX_W=3,
//    typedef enum logic [1:0] {FILL, LAUNCH, WAIT, HOLD} feed_state_t.
//  - One sub-module adder_feed_collector: lane register file + idx counter + clear; FSM,
//    wait counter and result register stay in the top.
// TESTING (bench models tree as registered 8-way sum with TREE_LAT delay)
//  - Reset then 8 beats 1..8 back-to-back -> lane_valid at T+1, m_valid at T+4, m_sum=36, m_count=8.
//  - 8 beats of 23'h7FFFFF -> m_sum=26'h3FFFFF8 (no truncation), m_count=8.
//  - s_valid toggled 1-0-1 with gaps, m_ready low 5 cycles in HOLD -> s_ready=0, m_sum stable,
//    one result only, then s_ready=1 cycle after handshake.
//  - rst asserted after 4 beats and again during WAIT -> all outputs 0, no m_valid; next full
//    group 10,20,..,80 -> m_sum=360.
//  - PARTIAL_EN: beats 5,6,7 with s_last on 7 -> lanes 3..7 = 0, m_sum=18, m_count=3;
//    without macro same stimulus plus 5 more beats of 1 -> m_sum=23, m_count=8.

Source files
------------

// File: rtl/adder_feed_pkg.sv
// -----------------------------------------------------------------------------
// adder_feed_pkg
// Shared constants and types for the adder-tree feeder block.
//   WIDTH    operand width per lane
//   LANES    lanes per group (tree depth 3, so fixed at 8)
//   TREE_LAT cycles from the lane launch edge to a valid tree_sum
//   SUM_W    full tree result width (WIDTH + log2(LANES))
//   IDX_W    lane index width
//   CNT_W    operand count width (1..8 needs 4 bits)
//   WAIT_W   wait counter width
// Optional feature macro used by the block: ADDER_FEED_PARTIAL_EN
// -----------------------------------------------------------------------------
package adder_feed_pkg;

    localparam int WIDTH    = 23;
    localparam int LANES    = 8;
    localparam int TREE_LAT = 2;
    localparam int SUM_W    = WIDTH + 3;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 4;
    localparam int WAIT_W   = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;

    typedef enum logic [1:0] {FILL, LAUNCH, WAIT, HOLD} feed_state_t;

endpackage

// File: rtl/adder_tree_feeder_if.sv
// -----------------------------------------------------------------------------
// adder_tree_feeder_if
// Operand stream and result stream of the adder-tree feeder.
//   s_valid/s_ready/s_data/s_last  operand beats (s_last only used when
//                                  ADDER_FEED_PARTIAL_EN is defined)
//   m_valid/m_ready/m_sum/m_count  result with operand count
// Modports:
//   slave  - the feeder itself (consumes operands, produces results)
//   master - the environment (produces operands, consumes results)
// -----------------------------------------------------------------------------
interface adder_tree_feeder_if;
    import adder_feed_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;

    logic             m_valid;
    logic             m_ready;
    logic [SUM_W-1:0] m_sum;
    logic [CNT_W-1:0] m_count;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_sum, m_count
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_sum, m_count
    );

endinterface

// File: rtl/adder_feed_collector.sv
// -----------------------------------------------------------------------------
// adder_feed_collector
// Lane register file for one operand group: each accepted beat is written to
// lane[idx] and idx advances. clear empties every lane and rewinds idx so that
// lanes not written by a short group read as zero.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      empty all lanes, idx = 0
//   wr_en      accepted operand beat
//   wr_data    operand to store in lane[idx]
//   lane_data  packed lanes, lane k at [k*WIDTH +: WIDTH]
//   idx        index of the next lane to be written
// -----------------------------------------------------------------------------
module adder_feed_collector
    import adder_feed_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [LANES*WIDTH-1:0] lane_data,
    output logic [IDX_W-1:0]       idx
);

    logic [WIDTH-1:0] lane_q [LANES];

    // NOTE: the lane array is reset on purpose: unwritten lanes must read as
    // zero because the tree adds all eight of them.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
            idx <= '0;
        end else if (wr_en) begin
            // NOTE: non-blocking so every register here updates from pre-edge values.
            lane_q[idx] <= wr_data;
            idx         <= idx + IDX_W'(1);
        end
    end

    // NOTE: lane_data gets a default before the loop so no latch can be inferred.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_data[k*WIDTH +: WIDTH] = lane_q[k];
        end
    end

endmodule

// File: rtl/adder_tree_feeder.sv
// -----------------------------------------------------------------------------
// adder_tree_feeder
// Collects a serial operand stream into 8 parallel lanes, launches them into an
// external adder tree with a one-cycle strobe, waits the fixed tree latency,
// captures the full-width sum and returns it on a valid/ready result port.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         adder_tree_feeder_if.slave (operand stream + result stream)
//   lane_data   packed lanes to the tree, lane 0 = first beat of the group
//   lane_valid  one-cycle launch strobe to the tree
//   tree_sum    sum returned by the tree, valid TREE_LAT cycles after launch
// Configuration:
//   ADDER_FEED_PARTIAL_EN  when defined, a beat with s_last=1 closes the group
//                          early; otherwise s_last is ignored and every group
//                          is exactly 8 beats.
// -----------------------------------------------------------------------------
module adder_tree_feeder
    import adder_feed_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    adder_tree_feeder_if.slave     bus,
    output logic [LANES*WIDTH-1:0] lane_data,
    output logic                   lane_valid,
    input  logic [SUM_W-1:0]       tree_sum
);

    feed_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  grp_count;
    logic [SUM_W-1:0]  m_sum_q;
    logic [CNT_W-1:0]  m_count_q;
    logic [IDX_W-1:0]  idx;
    logic              beat;
    logic              last_beat;
    logic              res_hs;

    // s_ready is gated by rst directly so it is low for the whole reset pulse
    // and rises in the first cycle after it.
    assign bus.s_ready = (state == FILL) && !rst;
    assign beat        = bus.s_valid && bus.s_ready;
    assign lane_valid  = (state == LAUNCH);
    assign bus.m_valid = (state == HOLD);
    assign res_hs      = bus.m_valid && bus.m_ready;
    assign bus.m_sum   = m_sum_q;
    assign bus.m_count = m_count_q;

`ifdef ADDER_FEED_PARTIAL_EN
    assign last_beat = beat && ((idx == IDX_W'(LANES - 1)) || bus.s_last);
`else
    assign last_beat = beat && (idx == IDX_W'(LANES - 1));
    logic unused_s_last;
    assign unused_s_last = bus.s_last;
`endif

    // Lanes are emptied on the result handshake, i.e. on the way back to FILL,
    // and stay constant from launch until the sum is captured.
    adder_feed_collector u_collector (
        .clk       (clk),
        .rst       (rst),
        .clear     (res_hs),
        .wr_en     (beat),
        .wr_data   (bus.s_data),
        .lane_data (lane_data),
        .idx       (idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wait_cnt  <= '0;
            grp_count <= '0;
            m_sum_q   <= '0;
            m_count_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (last_beat) begin
                        state     <= LAUNCH;
                        // idx still points at the lane being written this cycle.
                        grp_count <= CNT_W'(idx) + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_W'(TREE_LAT - 1);
                end
                WAIT: begin
                    // The launch edge counts as the first tree cycle, so the
                    // capture lands exactly TREE_LAT edges after it.
                    if (wait_cnt == '0) begin
                        state     <= HOLD;
                        m_sum_q   <= tree_sum;
                        m_count_q <= grp_count;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_feeder
// Drives operand groups into adder_tree_feeder, models the external adder tree
// as a registered 8-way sum with TREE_LAT delay, and checks results through a
// scoreboard: the input side of the monitor turns every completed group into an
// expected record (sum, count, lane image, cycle of its last beat); the output
// side compares handshake, latency and data against the oldest record.
// -----------------------------------------------------------------------------
module tb_adder_tree_feeder;
    import adder_feed_pkg::*;

    localparam int CW = LANES * WIDTH;

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic [CW-1:0]    lanes;
        int               t_last;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [CW-1:0]    lane_data;
    logic             lane_valid;
    logic [SUM_W-1:0] tree_sum;
    logic             m_ready_cmd;
    logic             rand_rdy;
    logic             rnd_rdy;

    int               total;
    int               bad;
    int               cyc;
    int               results;
    logic [SUM_W-1:0] last_sum;
    logic [CNT_W-1:0] last_count;
    exp_t             exp_q [$];

    adder_tree_feeder_if ifc ();

    assign ifc.m_ready = rand_rdy ? rnd_rdy : m_ready_cmd;

    adder_tree_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifc.slave),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .tree_sum   (tree_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External tree: input register sums all lanes every cycle, further
    // registers make up the rest of TREE_LAT.
    function automatic logic [SUM_W-1:0] lane_total(input logic [CW-1:0] l);
        logic [SUM_W-1:0] s = '0;
        for (int k = 0; k < LANES; k++) s += SUM_W'(l[k*WIDTH +: WIDTH]);
        return s;
    endfunction

    logic [SUM_W-1:0] tree_pipe [TREE_LAT];
    always @(posedge clk) begin
        tree_pipe[0] <= lane_total(lane_data);
        for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
    assign tree_sum = tree_pipe[TREE_LAT-1];

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        int               beats_in;
        logic [SUM_W-1:0] acc_sum;
        logic [CW-1:0]    acc_lanes;
        logic             rst_d;
        logic             busy;
        logic             is_last;
        exp_t             e;
        beats_in  = 0;
        acc_sum   = '0;
        acc_lanes = '0;
        rst_d     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("s_ready_in_reset", CW'(ifc.s_ready), CW'(0));
                if (rst_d) begin
                    check("rst_lane_valid", CW'(lane_valid), CW'(0));
                    check("rst_lane_data", lane_data, CW'(0));
                    check("rst_m_valid", CW'(ifc.m_valid), CW'(0));
                    check("rst_m_sum", CW'(ifc.m_sum), CW'(0));
                    check("rst_m_count", CW'(ifc.m_count), CW'(0));
                end
                exp_q.delete();
                beats_in  = 0;
                acc_sum   = '0;
                acc_lanes = '0;
            end else begin
                busy = (exp_q.size() > 0);
                if (busy) e = exp_q[0];
                check("s_ready", CW'(ifc.s_ready), CW'(!busy));
                check("lane_valid", CW'(lane_valid), CW'(busy && (cyc == e.t_last + 1)));
                check("m_valid", CW'(ifc.m_valid), CW'(busy && (cyc >= e.t_last + 2 + TREE_LAT)));
                if (busy && !ifc.m_valid && cyc > e.t_last)
                    check("lane_data_held", lane_data, e.lanes);
                if (busy && ifc.m_valid) begin
                    check("m_sum", CW'(ifc.m_sum), CW'(e.sum));
                    check("m_count", CW'(ifc.m_count), CW'(e.count));
                    if (ifc.m_ready) begin
                        last_sum   = ifc.m_sum;
                        last_count = ifc.m_count;
                        results++;
                        void'(exp_q.pop_front());
                    end
                end
                if (ifc.s_valid && ifc.s_ready) begin
                    acc_lanes[beats_in*WIDTH +: WIDTH] = ifc.s_data;
                    acc_sum += SUM_W'(ifc.s_data);
                    beats_in++;
                    is_last = (beats_in == LANES);
`ifdef ADDER_FEED_PARTIAL_EN
                    if (ifc.s_last) is_last = 1'b1;
`endif
                    if (is_last) begin
                        e.sum    = acc_sum;
                        e.count  = CNT_W'(beats_in);
                        e.lanes  = acc_lanes;
                        e.t_last = cyc;
                        exp_q.push_back(e);
                        beats_in  = 0;
                        acc_sum   = '0;
                        acc_lanes = '0;
                    end
                end
            end
            rst_d = rst;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input int gap);
        bit done = 1'b0;
        repeat (gap) step();
        ifc.s_valid = 1'b1;
        ifc.s_data  = d;
        ifc.s_last  = last;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (ifc.s_ready) done = 1'b1;
            step();
        end
        if (!done) check("beat_accept_timeout", CW'(done), CW'(1));
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (results < n && k < 100) begin
            step();
            k++;
        end
        check("result_timeout", CW'(results >= n), CW'(1));
    endtask

    initial begin
        int n0;
        int n;
        int k;
        logic lst;
        total       = 0;
        bad         = 0;
        results     = 0;
        last_sum    = '0;
        last_count  = '0;
        rst         = 1'b1;
        rand_rdy    = 1'b0;
        m_ready_cmd = 1'b1;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        ifc.s_last  = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Back-to-back 1..8.
        n0 = results;
        for (int i = 0; i < 8; i++) send_beat(WIDTH'(i + 1), 1'b0, 0);
        wait_results(n0 + 1);
        check("sum_1_to_8", CW'(last_sum), CW'(36));
        check("count_1_to_8", CW'(last_count), CW'(8));

        // Maximum operands, no truncation of the carry bits.
        n0 = results;
        for (int i = 0; i < 8; i++) send_beat(23'h7FFFFF, 1'b0, 0);
        wait_results(n0 + 1);
        check("sum_all_ones", CW'(last_sum), CW'(26'h3FFFFF8));
        check("count_all_ones", CW'(last_count), CW'(8));

        // Gapped input, result held back by m_ready.
        n0 = results;
        m_ready_cmd = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(WIDTH'(2 * (i + 1)), 1'b0, i % 2);
        k = 0;
        while (!ifc.m_valid && k < 20) begin
            step();
            k++;
        end
        check("hold_reached", CW'(ifc.m_valid), CW'(1));
        repeat (5) step();
        check("no_early_handshake", CW'(results), CW'(n0));
        m_ready_cmd = 1'b1;
        wait_results(n0 + 1);
        check("sum_gapped", CW'(last_sum), CW'(72));
        repeat (5) step();
        check("one_result_only", CW'(results), CW'(n0 + 1));

        // Reset mid-group, then reset during the tree wait.
        n0 = results;
        for (int i = 0; i < 4; i++) send_beat(WIDTH'(i + 1), 1'b0, 0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(WIDTH'(9), 1'b0, 0);
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (8) step();
        check("no_result_after_reset", CW'(results), CW'(n0));
        for (int i = 0; i < 8; i++) send_beat(WIDTH'(10 * (i + 1)), 1'b0, 0);
        wait_results(n0 + 1);
        check("sum_tens", CW'(last_sum), CW'(360));
        check("count_tens", CW'(last_count), CW'(8));

        // Short group: closes early only when partial groups are enabled.
        n0 = results;
        send_beat(WIDTH'(5), 1'b0, 0);
        send_beat(WIDTH'(6), 1'b0, 0);
        send_beat(WIDTH'(7), 1'b1, 0);
`ifdef ADDER_FEED_PARTIAL_EN
        wait_results(n0 + 1);
        check("sum_partial", CW'(last_sum), CW'(18));
        check("count_partial", CW'(last_count), CW'(3));
`else
        for (int i = 0; i < 5; i++) send_beat(WIDTH'(1), 1'b0, 0);
        wait_results(n0 + 1);
        check("sum_last_ignored", CW'(last_sum), CW'(23));
        check("count_last_ignored", CW'(last_count), CW'(8));
`endif

        // Random groups with random gaps and random result back-pressure.
        n0 = results;
        rand_rdy = 1'b1;
        for (int g = 0; g < 20; g++) begin
`ifdef ADDER_FEED_PARTIAL_EN
            n = $urandom_range(1, LANES);
`else
            n = LANES;
`endif
            for (int i = 0; i < n; i++) begin
`ifdef ADDER_FEED_PARTIAL_EN
                lst = (i == n - 1);
`else
                lst = 1'($urandom_range(0, 1));
`endif
                send_beat(WIDTH'($urandom), lst, $urandom_range(0, 2));
            end
        end
        rand_rdy    = 1'b0;
        m_ready_cmd = 1'b1;
        wait_results(n0 + 20);
        repeat (5) step();
        check("queue_drained", CW'(exp_q.size()), CW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
